// File: rtl/ysyx_22040237_pkg.sv
// Shared encodings and width constants for the ysyx_22040237 multiply/divide unit.
package ysyx_22040237_pkg;

    localparam int unsigned OP_W  = 4;
    localparam int unsigned TAG_W = 5;
    // Counter holds up to 64 iterations
    localparam int unsigned CNT_W = 7;

    typedef enum logic [2:0] {
        F3_MUL    = 3'b000,
        F3_MULH   = 3'b001,
        F3_MULHSU = 3'b010,
        F3_MULHU  = 3'b011,
        F3_DIV    = 3'b100,
        F3_DIVU   = 3'b101,
        F3_REM    = 3'b110,
        F3_REMU   = 3'b111
    } funct3_e;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_PREP  = 3'd1,
        ST_CALC  = 3'd2,
        ST_FIXUP = 3'd3,
        ST_DONE  = 3'd4
    } state_e;

endpackage

// File: rtl/ysyx_22040237_mdu_if.sv
// Issue/result handshake bundle between the execute stage and the multiply/divide unit.
interface ysyx_22040237_mdu_if #(
    parameter int unsigned XLEN = 64
);
    logic                                 in_valid_i;
    logic                                 in_ready_o;
    logic [ysyx_22040237_pkg::OP_W-1:0]   op_i;
    logic [XLEN-1:0]                      op1_i;
    logic [XLEN-1:0]                      op2_i;
    logic [ysyx_22040237_pkg::TAG_W-1:0]  rd_idx_i;
    logic                                 flush_i;
    logic                                 out_valid_o;
    logic                                 out_ready_i;
    logic [XLEN-1:0]                      res_o;
    logic [ysyx_22040237_pkg::TAG_W-1:0]  rd_idx_o;

    modport slave (
        input  in_valid_i, op_i, op1_i, op2_i, rd_idx_i, flush_i, out_ready_i,
        output in_ready_o, out_valid_o, res_o, rd_idx_o
    );

    modport master (
        output in_valid_i, op_i, op1_i, op2_i, rd_idx_i, flush_i, out_ready_i,
        input  in_ready_o, out_valid_o, res_o, rd_idx_o
    );
endinterface

// File: rtl/ysyx_22040237_div_step.sv
// One restoring-division step: shift in the next dividend bit, trial-subtract the divisor.
module ysyx_22040237_div_step #(
    parameter int unsigned XLEN = 64
) (
    input  logic [XLEN-1:0] rem_i,
    input  logic            msb_i,
    input  logic [XLEN-1:0] div_i,
    output logic [XLEN-1:0] rem_o,
    output logic            q_o
);
    logic [XLEN:0] sh_c;
    logic [XLEN:0] diff_c;

    // Partial remainder stays below the divisor, so bit XLEN of the difference is the borrow
    always_comb begin
        sh_c   = {rem_i, msb_i};
        diff_c = sh_c - {1'b0, div_i};
        q_o    = ~diff_c[XLEN];
        rem_o  = q_o ? diff_c[XLEN-1:0] : sh_c[XLEN-1:0];
    end
endmodule

// File: rtl/ysyx_22040237_mdu.sv
// Iterative RV64M multiply/divide unit (shift-add multiply, restoring divide).
// Optional YSYX_22040237_MDU_EARLY_OUT_EN: trivial operands finish straight from PREP.
module ysyx_22040237_mdu
    import ysyx_22040237_pkg::*;
#(
    parameter int unsigned XLEN = 64,
    parameter bit          W_EN = 1'b1
) (
    input  logic                clk,
    input  logic                rst,
    ysyx_22040237_mdu_if.slave  bus
);
    localparam int unsigned X2   = 2 * XLEN;
    localparam bit          W_OK = W_EN && (XLEN == 64);

    state_e           st_q;
    funct3_e          f3_q;
    logic             w_q;
    logic [XLEN-1:0]  a_q, b_q, mc_q, res_q;
    logic [X2-1:0]    acc_q;
    logic [CNT_W-1:0] cnt_q;
    logic [TAG_W-1:0] tag_q;
    logic             neg_q, rneg_q, div0_q, in_ready_q, out_valid_q;

    function automatic logic [XLEN-1:0] sext32(input logic [31:0] v);
        return XLEN'($signed(v));
    endfunction

    // Operand extension and magnitudes used while in PREP
    logic            sa_c, sb_c, a_sgn_c, b_sgn_c;
    logic [XLEN-1:0] a_ext_c, b_ext_c, a_mag_c, b_mag_c;
    always_comb begin
        sa_c    = f3_q inside {F3_MULH, F3_MULHSU, F3_DIV, F3_REM};
        sb_c    = f3_q inside {F3_MULH, F3_DIV, F3_REM};
        a_ext_c = a_q;
        b_ext_c = b_q;
        if (w_q) begin
            a_ext_c = sa_c ? sext32(a_q[31:0]) : XLEN'(a_q[31:0]);
            b_ext_c = sb_c ? sext32(b_q[31:0]) : XLEN'(b_q[31:0]);
        end
        a_sgn_c = sa_c & a_ext_c[XLEN-1];
        b_sgn_c = sb_c & b_ext_c[XLEN-1];
        a_mag_c = a_sgn_c ? -a_ext_c : a_ext_c;
        b_mag_c = b_sgn_c ? -b_ext_c : b_ext_c;
    end

    // Multiply iteration: conditional add into the high half, then shift the pair right
    logic [XLEN:0]   mul_sum_c;
    logic [X2-1:0]   mul_nxt_c;
    always_comb begin
        mul_sum_c = {1'b0, acc_q[X2-1:XLEN]} + (acc_q[0] ? {1'b0, mc_q} : '0);
        mul_nxt_c = {mul_sum_c, acc_q[XLEN-1:1]};
    end

    // Divide iteration: acc holds {remainder, dividend/quotient}
    logic [XLEN-1:0] div_rem_c;
    logic            div_q_c;
    logic [X2-1:0]   div_nxt_c;
    ysyx_22040237_div_step #(.XLEN(XLEN)) u_div_step (
        .rem_i (acc_q[X2-1:XLEN]),
        .msb_i (acc_q[XLEN-1]),
        .div_i (mc_q),
        .rem_o (div_rem_c),
        .q_o   (div_q_c)
    );
    assign div_nxt_c = {div_rem_c, acc_q[XLEN-2:0], div_q_c};

    // Sign correction and result selection in FIXUP
    logic [X2-1:0]   prod_c;
    logic [XLEN-1:0] quo_c, rem_c, fix_c;
    always_comb begin
        prod_c = neg_q ? -acc_q : acc_q;
        quo_c  = (neg_q & ~div0_q) ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
        rem_c  = rneg_q ? -acc_q[X2-1:XLEN] : acc_q[X2-1:XLEN];
        fix_c  = '0;
        case (f3_q)
            F3_MUL:                       fix_c = w_q ? sext32(acc_q[XLEN-32 +: 32]) : acc_q[XLEN-1:0];
            F3_MULH, F3_MULHSU, F3_MULHU: fix_c = prod_c[X2-1:XLEN];
            F3_DIV, F3_DIVU:              fix_c = w_q ? sext32(quo_c[31:0]) : quo_c;
            F3_REM, F3_REMU:              fix_c = w_q ? sext32(rem_c[31:0]) : rem_c;
        endcase
    end

`ifdef YSYX_22040237_MDU_EARLY_OUT_EN
    // Divide-by-zero, signed overflow and zero multiply operands have closed-form results
    logic            eo_hit_c;
    logic [XLEN-1:0] eo_res_c, min_c;
    always_comb begin
        min_c    = w_q ? sext32(32'h8000_0000) : {1'b1, {(XLEN-1){1'b0}}};
        eo_hit_c = 1'b0;
        eo_res_c = '0;
        if (f3_q[2]) begin
            if (b_ext_c == '0) begin
                eo_hit_c = 1'b1;
                eo_res_c = f3_q[1] ? a_ext_c : '1;
            end else if (sb_c && (b_ext_c == '1) && (a_ext_c == min_c)) begin
                eo_hit_c = 1'b1;
                eo_res_c = f3_q[1] ? '0 : a_ext_c;
            end
        end else if ((a_ext_c == '0) || (b_ext_c == '0)) begin
            eo_hit_c = 1'b1;
        end
        if (w_q) eo_res_c = sext32(eo_res_c[31:0]);
    end
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            st_q        <= ST_IDLE;
            f3_q        <= F3_MUL;
            w_q         <= 1'b0;
            a_q         <= '0;
            b_q         <= '0;
            mc_q        <= '0;
            res_q       <= '0;
            acc_q       <= '0;
            cnt_q       <= '0;
            tag_q       <= '0;
            neg_q       <= 1'b0;
            rneg_q      <= 1'b0;
            div0_q      <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            case (st_q)
                ST_IDLE: if (bus.in_valid_i) begin
                    f3_q       <= funct3_e'(bus.op_i[2:0]);
                    w_q        <= W_OK & bus.op_i[3] & (bus.op_i[2] | (bus.op_i[1:0] == 2'b00));
                    a_q        <= bus.op1_i;
                    b_q        <= bus.op2_i;
                    tag_q      <= bus.rd_idx_i;
                    in_ready_q <= 1'b0;
                    st_q       <= ST_PREP;
                end
                ST_PREP: begin
                    neg_q  <= a_sgn_c ^ b_sgn_c;
                    rneg_q <= a_sgn_c;
                    div0_q <= (b_mag_c == '0);
                    cnt_q  <= w_q ? CNT_W'(32) : CNT_W'(XLEN);
                    if (f3_q[2]) begin
                        // W divides pre-align the 32-bit dividend so 32 steps consume it
                        mc_q  <= b_mag_c;
                        acc_q <= {{XLEN{1'b0}}, (w_q ? (a_mag_c << (XLEN - 32)) : a_mag_c)};
                    end else begin
                        mc_q  <= a_mag_c;
                        acc_q <= {{XLEN{1'b0}}, b_mag_c};
                    end
                    st_q <= ST_CALC;
`ifdef YSYX_22040237_MDU_EARLY_OUT_EN
                    if (eo_hit_c) begin
                        res_q       <= eo_res_c;
                        out_valid_q <= 1'b1;
                        st_q        <= ST_DONE;
                    end
`endif
                end
                ST_CALC: begin
                    acc_q <= f3_q[2] ? div_nxt_c : mul_nxt_c;
                    cnt_q <= cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1)) st_q <= ST_FIXUP;
                end
                ST_FIXUP: begin
                    res_q       <= fix_c;
                    out_valid_q <= 1'b1;
                    st_q        <= ST_DONE;
                end
                ST_DONE: if (bus.out_ready_i) begin
                    out_valid_q <= 1'b0;
                    in_ready_q  <= 1'b1;
                    st_q        <= ST_IDLE;
                end
                default: begin
                    out_valid_q <= 1'b0;
                    in_ready_q  <= 1'b1;
                    st_q        <= ST_IDLE;
                end
            endcase
            // Flush kills any in-flight op; an idle unit ignores it
            if (bus.flush_i && (st_q != ST_IDLE)) begin
                out_valid_q <= 1'b0;
                in_ready_q  <= 1'b1;
                st_q        <= ST_IDLE;
            end
        end
    end

    assign bus.in_ready_o  = in_ready_q;
    assign bus.out_valid_o = out_valid_q;
    assign bus.res_o       = res_q;
    assign bus.rd_idx_o    = tag_q;
endmodule

// File: tb/tb_ysyx_22040237_mdu.sv
// Directed self-checking bench for ysyx_22040237_mdu (XLEN=64).
module tb_ysyx_22040237_mdu;

    logic clk;
    logic rst;
    int   n_chk;
    int   n_pass;

`ifdef YSYX_22040237_MDU_EARLY_OUT_EN
    localparam int LAT_TRIV = 0;
`else
    localparam int LAT_TRIV = 66;
`endif

    ysyx_22040237_mdu_if #(.XLEN(64)) bus ();

    ysyx_22040237_mdu #(.XLEN(64), .W_EN(1'b1)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, act, exp);
    endtask

    // Offer one op; returns #1 after the accepting edge
    task automatic issue(input logic [3:0] op, input logic [63:0] a, input logic [63:0] b,
                         input logic [4:0] idx);
        bus.in_valid_i = 1'b1;
        bus.op_i       = op;
        bus.op1_i      = a;
        bus.op2_i      = b;
        bus.rd_idx_i   = idx;
        @(posedge clk); #1;
        bus.in_valid_i = 1'b0;
    endtask

    task automatic wait_valid(output int lat);
        lat = 0;
        while (!bus.out_valid_o && lat < 200) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic run_op(input string tag, input logic [3:0] op, input logic [63:0] a,
                          input logic [63:0] b, input logic [4:0] idx,
                          input logic [63:0] exp, input int exp_lat);
        int lat;
        chk({tag, "_rdy"}, 64'(bus.in_ready_o), 64'd1);
        issue(op, a, b, idx);
        wait_valid(lat);
        if (exp_lat != 0) chk({tag, "_lat"}, 64'(lat), 64'(exp_lat));
        else              chk({tag, "_vld"}, 64'(bus.out_valid_o), 64'd1);
        chk({tag, "_res"}, bus.res_o, exp);
        chk({tag, "_idx"}, 64'(bus.rd_idx_o), 64'(idx));
        @(posedge clk); #1;
        chk({tag, "_back"}, 64'({bus.in_ready_o, bus.out_valid_o}), 64'b10);
    endtask

    initial begin
        int lat;
        int seen;
        n_chk  = 0;
        n_pass = 0;
        rst             = 1'b0;
        bus.in_valid_i  = 1'b0;
        bus.op_i        = '0;
        bus.op1_i       = '0;
        bus.op2_i       = '0;
        bus.rd_idx_i    = '0;
        bus.flush_i     = 1'b0;
        bus.out_ready_i = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ready", 64'(bus.in_ready_o),  64'd1);
        chk("rst_valid", 64'(bus.out_valid_o), 64'd0);
        chk("rst_res",   bus.res_o,            64'd0);
        chk("rst_idx",   64'(bus.rd_idx_o),    64'd0);
        rst = 1'b1;
        @(posedge clk); #1;

        run_op("mul",     4'b0000, 64'd7, 64'hFFFF_FFFF_FFFF_FFFD, 5'd9, 64'hFFFF_FFFF_FFFF_FFEB, 66);
        run_op("mulh",    4'b0001, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 5'd1,
               64'h4000_0000_0000_0000, 66);
        run_op("mulhu",   4'b0011, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 5'd2,
               64'hFFFF_FFFF_FFFF_FFFE, 66);
        run_op("mulhsu",  4'b0010, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 5'd3, 64'hFFFF_FFFF_FFFF_FFFF, 66);
        run_op("divu0",   4'b0101, 64'd123, 64'd0, 5'd4, 64'hFFFF_FFFF_FFFF_FFFF, LAT_TRIV);
        run_op("remu0",   4'b0111, 64'd123, 64'd0, 5'd5, 64'd123, LAT_TRIV);
        run_op("div0",    4'b0100, 64'hFFFF_FFFF_FFFF_FFFB, 64'd0, 5'd6, 64'hFFFF_FFFF_FFFF_FFFF, LAT_TRIV);
        run_op("rem0",    4'b0110, 64'hFFFF_FFFF_FFFF_FFFB, 64'd0, 5'd7, 64'hFFFF_FFFF_FFFF_FFFB, LAT_TRIV);
        run_op("divovf",  4'b0100, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 5'd8,
               64'h8000_0000_0000_0000, LAT_TRIV);
        run_op("removf",  4'b0110, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 5'd10, 64'd0, LAT_TRIV);
        run_op("div",     4'b0100, 64'hFFFF_FFFF_FFFF_FFEC, 64'd3, 5'd11, 64'hFFFF_FFFF_FFFF_FFFA, 66);
        run_op("rem",     4'b0110, 64'hFFFF_FFFF_FFFF_FFEC, 64'd3, 5'd12, 64'hFFFF_FFFF_FFFF_FFFE, 66);
        run_op("divu",    4'b0101, 64'd100, 64'd7, 5'd13, 64'd14, 66);
        run_op("remu",    4'b0111, 64'd100, 64'd7, 5'd14, 64'd2, 66);
        run_op("divw",    4'b1100, 64'h0000_0001_8000_0000, 64'd2, 5'd15, 64'hFFFF_FFFF_C000_0000, 34);
        run_op("mulw",    4'b1000, 64'h0000_0000_7FFF_FFFF, 64'd2, 5'd16, 64'hFFFF_FFFF_FFFF_FFFE, 34);
        run_op("rsvw",    4'b1011, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 5'd18, 64'd1, 66);

        // Flush on the tenth CALC cycle
        issue(4'b0100, 64'd100, 64'd7, 5'd3);
        repeat (10) @(posedge clk);
        #1;
        chk("fl_busy", 64'(bus.in_ready_o), 64'd0);
        bus.flush_i = 1'b1;
        @(posedge clk); #1;
        bus.flush_i = 1'b0;
        chk("fl_ready", 64'({bus.in_ready_o, bus.out_valid_o}), 64'b10);
        seen = 0;
        for (int i = 0; i < 80; i++) begin
            @(posedge clk); #1;
            if (bus.out_valid_o) seen++;
        end
        chk("fl_novalid", 64'(seen), 64'd0);
        run_op("after_fl", 4'b0101, 64'd100, 64'd7, 5'd19, 64'd14, 66);

        // Output backpressure
        bus.out_ready_i = 1'b0;
        issue(4'b0000, 64'd3, 64'd5, 5'd17);
        wait_valid(lat);
        chk("bp_lat", 64'(lat), 64'd66);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            chk("bp_res",   bus.res_o, 64'd15);
            chk("bp_idx",   64'(bus.rd_idx_o), 64'd17);
            chk("bp_state", 64'({bus.in_ready_o, bus.out_valid_o}), 64'b01);
        end
        bus.out_ready_i = 1'b1;
        @(posedge clk); #1;
        chk("bp_release", 64'({bus.in_ready_o, bus.out_valid_o}), 64'b10);

        // Reset asserted mid-op
        issue(4'b0001, 64'd5, 64'd9, 5'd21);
        repeat (5) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        chk("mrst_state", 64'({bus.in_ready_o, bus.out_valid_o}), 64'b10);
        chk("mrst_res",   bus.res_o, 64'd0);
        chk("mrst_idx",   64'(bus.rd_idx_o), 64'd0);
        rst = 1'b1;
        @(posedge clk); #1;
        run_op("after_rst", 4'b0000, 64'd6, 64'd7, 5'd22, 64'd42, 66);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
